printhead_line_seq: RTL and testbench

Line sequencer for the 384-dot thermal printhead. On a start request it reads one print line (48 bytes) from the line buffer and shifts it out on SCLK/DO. It then pulses LAT and fires the six strobe groups STB[0..5] one at a time, each for a programmable heat time. It sits between the line buffer and the printhead pins and owns all head timing; upstream logic only issues start/abort and watches busy/done.

---
 rtl/printhead_pkg.sv | 22 ++
 rtl/ph_pulse_timer.sv | 25 ++
 rtl/printhead_line_seq.sv | 150 +++++++++++++++
 tb/tb_printhead_line_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/printhead_pkg.sv
// Shared types and geometry for the thermal printhead line sequencer.
package printhead_pkg;

  localparam int unsigned N_DOTS         = 384;
  localparam int unsigned N_GROUPS       = 6;
  localparam int unsigned BYTES_PER_LINE = N_DOTS / 8;
  localparam int unsigned ADDR_W         = 6;

  localparam logic [ADDR_W-1:0] LAST_BYTE  = ADDR_W'(BYTES_PER_LINE - 1);
  localparam logic [2:0]        LAST_GROUP = 3'(N_GROUPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StShift,
    StLatch,
    StGap,
    StStrobe
  } ph_state_e;

endpackage

// File: rtl/ph_pulse_timer.sv
// Loadable 16-bit down-counter; expire is high in the last cycle of a loaded interval.
module ph_pulse_timer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expire
);

  logic [15:0] cnt_q;

  // load_val counts cycles, so an interval of N ends when the counter reaches 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val - 16'd1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/printhead_line_seq.sv
// Line sequencer: fetches 48 bytes, shifts them to the head, latches, then fires six strobe groups.
module printhead_line_seq
  import printhead_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned LAT_CYCLES = 10,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         stb_time,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [7:0]          rd_data,
  output logic                SCLK,
  output logic                DO,
  output logic                LAT,
  output logic [N_GROUPS-1:0] STB,
  output logic                busy,
  output logic                done
);

  ph_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [2:0]        bit_q;
  logic              half_q;
  logic [7:0]        sr_q;
  logic [2:0]        group_q;
  logic [15:0]       stb_len_q;
  logic              done_q;

  logic              tmr_load;
  logic [15:0]       tmr_val;
  logic              tmr_expire;
  logic              byte_end;

  ph_pulse_timer u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign byte_end = (state_q == StShift) && tmr_expire && half_q && (bit_q == 3'd7);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = StCapture;
      StCapture: state_d = StShift;
      StShift:   if (byte_end) state_d = (idx_q == LAST_BYTE) ? StLatch : StFetch;
      StLatch:   if (tmr_expire) state_d = StGap;
      StGap:     if (tmr_expire) state_d = StStrobe;
      StStrobe:  if (tmr_expire) state_d = (group_q == LAST_GROUP) ? StIdle : StGap;
      default:   state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Timer is reloaded on entry to every timed state and on each SCLK half-period boundary.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 16'(CLK_DIV);
    unique case (state_d)
      StShift: begin
        tmr_load = (state_q != StShift) || tmr_expire;
        tmr_val  = 16'(CLK_DIV);
      end
      StLatch: begin
        tmr_load = (state_q != StLatch);
        tmr_val  = 16'(LAT_CYCLES);
      end
      StGap: begin
        tmr_load = (state_q != StGap);
        tmr_val  = 16'(GAP_CYCLES);
      end
      StStrobe: begin
        tmr_load = (state_q != StStrobe);
        tmr_val  = stb_len_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q     <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      sr_q      <= '0;
      group_q   <= '0;
      stb_len_q <= 16'd1;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StStrobe) && tmr_expire && (group_q == LAST_GROUP) && !abort;
      if ((state_q == StIdle) && start && !abort) begin
        idx_q     <= '0;
        group_q   <= '0;
        stb_len_q <= (stb_time == 16'd0) ? 16'd1 : stb_time;
      end
      if (state_q == StCapture) begin
        sr_q   <= rd_data;
        bit_q  <= '0;
        half_q <= 1'b0;
      end
      // sr_q[7] drives DO; shifting at the end of a high phase presents the next bit
      // on the first low cycle, and the last bit stays put until the next line.
      if ((state_q == StShift) && tmr_expire) begin
        half_q <= ~half_q;
        if (half_q) begin
          bit_q <= bit_q + 3'd1;
          if (bit_q != 3'd7) begin
            sr_q <= {sr_q[6:0], 1'b0};
          end else if (idx_q != LAST_BYTE) begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
      end
      if ((state_q == StStrobe) && tmr_expire && (group_q != LAST_GROUP)) begin
        group_q <= group_q + 3'd1;
      end
    end
  end

  always_comb begin
    rd_en = (state_q == StFetch);
    SCLK  = (state_q == StShift) && half_q;
    LAT   = (state_q == StLatch);
    busy  = (state_q != StIdle);
    STB   = '0;
    if (state_q == StStrobe) STB = N_GROUPS'(1) << group_q;
  end

  assign rd_addr = idx_q;
  assign DO      = sr_q[7];
  assign done    = done_q;

endmodule

// File: tb/tb_printhead_line_seq.sv
// Directed bench for printhead_line_seq with a line-buffer model and pin monitors.
module tb_printhead_line_seq;

  localparam int unsigned CLK_DIV_P = 2;
  localparam int unsigned LAT_P     = 10;
  localparam int unsigned GAP_P     = 2;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        abort;
  logic [15:0] stb_time;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        SCLK;
  logic        DO;
  logic        LAT;
  logic [5:0]  STB;
  logic        busy;
  logic        done;

  printhead_line_seq #(
    .CLK_DIV    (CLK_DIV_P),
    .LAT_CYCLES (LAT_P),
    .GAP_CYCLES (GAP_P)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .abort    (abort),
    .stb_time (stb_time),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .SCLK     (SCLK),
    .DO       (DO),
    .LAT      (LAT),
    .STB      (STB),
    .busy     (busy),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line buffer: byte at address a is a ^ key, returned one cycle after rd_en.
  logic [7:0] key;
  initial rd_data = 8'h00;
  always @(posedge CLK) if (rd_en) rd_data <= {2'b00, rd_addr} ^ key;

  int n_checks;
  int n_fail;

  // Monitor: cumulative counters sampled on the falling edge.
  int         busy_total, rise_total, lat_total, done_total, done_bad;
  int         do_err, onehot_err, bit_pos;
  int         stb_tot[6];
  int         stb_seq[$];
  logic [5:0] cur_byte;
  logic       prev_sclk, prev_busy;
  logic [5:0] prev_stb;
  logic [7:0] exp_b;

  initial begin
    busy_total = 0; rise_total = 0; lat_total = 0; done_total = 0; done_bad = 0;
    do_err = 0; onehot_err = 0; bit_pos = 0; cur_byte = '0;
    prev_sclk = 1'b0; prev_busy = 1'b0; prev_stb = '0;
    for (int g = 0; g < 6; g++) stb_tot[g] = 0;
  end

  always @(negedge CLK) begin
    if (busy) busy_total++;
    if (LAT) lat_total++;
    if (done) begin
      done_total++;
      if (busy || !prev_busy) done_bad++;
    end
    if (rd_en) begin
      cur_byte = rd_addr;
      bit_pos  = 0;
    end
    if (SCLK && !prev_sclk) begin
      rise_total++;
      exp_b = {2'b00, cur_byte} ^ key;
      if (bit_pos > 7) do_err++;
      else if (DO !== exp_b[7-bit_pos]) do_err++;
      bit_pos++;
    end
    if ($countones(STB) > 1) onehot_err++;
    for (int g = 0; g < 6; g++) begin
      if (STB[g]) begin
        stb_tot[g]++;
        if (STB != prev_stb) stb_seq.push_back(g);
      end
    end
    prev_sclk = SCLK;
    prev_busy = busy;
    prev_stb  = STB;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_line(input logic [15:0] st);
    stb_time = st;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_within_bound", int'(done), 1);
  endtask

  task automatic wait_stb(input logic [5:0] pat, input int bound);
    int n = 0;
    while (STB != pat && n < bound) begin
      tick();
      n++;
    end
    check("stb_reached", int'(STB), int'(pat));
  endtask

  task automatic run_line(input logic [7:0] k, input logic [15:0] st,
                          input int exp_busy, input int exp_len);
    int b0, r0, l0, d0, e0, h0, db0, q0;
    int s0[6];
    key = k;
    b0 = busy_total; r0 = rise_total; l0 = lat_total; d0 = done_total;
    e0 = do_err; h0 = onehot_err; db0 = done_bad; q0 = stb_seq.size();
    for (int g = 0; g < 6; g++) s0[g] = stb_tot[g];
    start_line(st);
    wait_done(6000);
    repeat (3) tick();
    check("busy_cycles", busy_total - b0, exp_busy);
    check("sclk_rises", rise_total - r0, 384);
    check("do_bit_errors", do_err - e0, 0);
    check("lat_cycles", lat_total - l0, LAT_P);
    check("done_pulses", done_total - d0, 1);
    check("done_vs_busy", done_bad - db0, 0);
    check("stb_multi_hot", onehot_err - h0, 0);
    check("stb_pulse_count", stb_seq.size() - q0, 6);
    for (int g = 0; g < 6; g++) begin
      check("stb_len", stb_tot[g] - s0[g], exp_len);
      if (stb_seq.size() - q0 == 6) check("stb_order", stb_seq[q0 + g], g);
    end
  endtask

  typedef struct {
    logic [7:0]  key;
    logic [15:0] stb;
    int          exp_busy;
    int          exp_len;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int nz, b0, b1, d0, s4, s5;
    n_checks = 0;
    n_fail   = 0;
    key      = 8'h00;
    RST_N    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    stb_time = 16'd0;

    // busy = 48*(2+16*2) + 10 + 6*2 + 6*max(stb,1) = 1654 + 6*max(stb,1)
    vecs[0] = '{key: 8'h00, stb: 16'd100, exp_busy: 2254, exp_len: 100};
    vecs[1] = '{key: 8'hA5, stb: 16'd0,   exp_busy: 1660, exp_len: 1};
    vecs[2] = '{key: 8'h3C, stb: 16'd7,   exp_busy: 1696, exp_len: 7};

    repeat (3) tick();
    check("reset_outputs", int'({SCLK, DO, LAT, STB, rd_en, rd_addr, busy, done}), 0);
    RST_N = 1'b1;
    nz = 0;
    repeat (100) begin
      tick();
      if ({SCLK, DO, LAT, STB, rd_en, rd_addr, busy, done} != '0) nz++;
    end
    check("idle_outputs_nonzero_cycles", nz, 0);

    for (int i = 0; i < 3; i++) run_line(vecs[i].key, vecs[i].stb, vecs[i].exp_busy, vecs[i].exp_len);

    // start while busy is ignored
    key = 8'h00;
    b0 = busy_total;
    d0 = done_total;
    start_line(16'd5);
    nz = 0;
    while (!SCLK && nz < 200) begin tick(); nz++; end
    check("sclk_seen", int'(SCLK), 1);
    start = 1'b1; tick(); start = 1'b0;
    wait_stb(6'b000001, 3000);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(3000);
    repeat (50) tick();
    check("ignored_start_done_count", done_total - d0, 1);
    check("ignored_start_busy_cycles", busy_total - b0, 1684);
    check("ignored_start_idle", int'(busy), 0);

    // abort during strobe group 3
    d0 = done_total;
    start_line(16'd20);
    wait_stb(6'b001000, 4000);
    s4 = stb_tot[4];
    s5 = stb_tot[5];
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_stb", int'(STB), 0);
    check("abort_busy", int'(busy), 0);
    repeat (200) tick();
    check("abort_no_done", done_total - d0, 0);
    check("abort_group4", stb_tot[4] - s4, 0);
    check("abort_group5", stb_tot[5] - s5, 0);
    run_line(8'hC3, 16'd2, 1666, 2);

    // asynchronous reset while STB[2] is high
    start_line(16'd50);
    wait_stb(6'b000100, 4000);
    #1 RST_N = 1'b0;
    #1;
    check("async_reset_outputs", int'({SCLK, DO, LAT, STB, rd_en, rd_addr, busy, done}), 0);
    tick();
    tick();
    RST_N = 1'b1;
    b0 = busy_total;
    repeat (10) tick();
    check("post_reset_idle_busy", busy_total - b0, 0);
    check("post_reset_stb", int'(STB), 0);

    // back-to-back lines: start on the done cycle
    key = 8'h5A;
    b0 = busy_total;
    start_line(16'd3);
    wait_done(3000);
    check("b2b_first_busy", busy_total - b0, 1672);
    b1 = busy_total;
    d0 = done_total;
    start = 1'b1; tick(); start = 1'b0;
    check("b2b_busy_next", int'(busy), 1);
    check("b2b_rd_en_next", int'(rd_en), 1);
    check("b2b_rd_addr", int'(rd_addr), 0);
    check("b2b_done_cleared", int'(done), 0);
    wait_done(3000);
    check("b2b_second_busy", busy_total - b1, 1672);
    check("b2b_second_done", done_total - d0, 1);
    check("b2b_multi_hot", onehot_err, 0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
